cc_speed_counter: RTL
=====================

# cc_speed_counter

Level-aware up-counter that sits directly upstream of the lane speed comparator in the Frogger datapath. It produces the 24-bit count bus the comparator tests against its terminal value, and takes the comparator's registered-clear output back as its synchronous clear. It also counts completed periods. After a programmable number of periods it raises the game level, which enlarges the count step so lanes move faster.

## Interface
- SPEEDCOUNTER_DATAWIDTH, 24: count bus width.
- SPEEDCOUNTER_TERMINAL, 24'd16500000: terminal count. Must equal the comparator's compare constant.
- SPEEDCOUNTER_LEVELWIDTH, 3: level register width.
- SPEEDCOUNTER_MAXLEVEL, 7: saturation level.
- SPEEDCOUNTER_TICKSPERLEVEL, 8: completed periods per level increment. Must be at least 1 and at most 255.
- CC_SPEEDCOUNTER_CLOCK_50  in  1  system clock, rising edge.
- CC_SPEEDCOUNTER_RESET_InHigh  in  1  asynchronous, active-high reset.
- CC_SPEEDCOUNTER_clear_InHigh  in  1  synchronous clear, driven by the comparator output.
- CC_SPEEDCOUNTER_enable_InHigh  in  1  count enable. 0 = pause and hold.
- CC_SPEEDCOUNTER_restart_InHigh  in  1  synchronous game restart.
- CC_SPEEDCOUNTER_data_OutBUS  out  DATAWIDTH  current count, which feeds the comparator.
- CC_SPEEDCOUNTER_level_OutBUS  out  LEVELWIDTH  current level.
- CC_SPEEDCOUNTER_tick_OutHigh  out  1  one-cycle pulse per completed period.

## Operation
- State registers:
  - count, DATAWIDTH bits.
  - level, LEVELWIDTH bits.
  - tickcnt, 8 bits.
  - tick, 1 bit.
- All outputs come directly from these registers.
- step = level + 1.
- Sum is computed as count + step, DATAWIDTH+1 bits wide, with no wrap.
- Next-count priority, highest first:
  1. restart → 0.
  2. clear → 0.
  3. enable=0 → hold.
  4. sum ≥ TERMINAL, or count > TERMINAL → TERMINAL (saturating load).
  5. Otherwise → sum.
- Because of the saturating load, count never skips the exact TERMINAL value the equality comparator needs.
- tickcond = (count == TERMINAL) && clear && !restart.
  - tickcond is independent of enable.
  - A clear asserted while count ≠ TERMINAL (comparator start-hold) never produces a tick.
- tick register ← tickcond every cycle. The result is a single-cycle pulse after each terminal clear.
- On tickcond:
  - If tickcnt == TICKSPERLEVEL−1: tickcnt ← 0, and level ← level+1 when level < MAXLEVEL, otherwise level holds.
  - Else: tickcnt ← tickcnt+1.
- On restart: level ← 0, tickcnt ← 0, tick ← 0, count ← 0, regardless of every other input.
- Levels only increase, except on restart or reset.

## Timing
- Reset (asynchronous, immediate): count = 0, level = 0, tickcnt = 0, tick = 0.
  - These values are held while reset is high.
  - The first count advance happens on the first rising edge after deassertion, provided enable=1 and clear=0.
- Count updates once per edge. There is no internal latency beyond one register stage.
- clear is sampled combinationally from the comparator, which depends on data_OutBUS.
  - Loop timing: count reaches TERMINAL at edge N, clear is high during cycle N, count = 0 after edge N+1.
- Period is ceil(TERMINAL/step) + 1 cycles with enable held at 1.
  - Example, TERMINAL = 10: level 0 → 11 cycles, level 1 → 6, level 2 → 5, level 3 → 4.
- tick_OutHigh is high in the cycle immediately after the TERMINAL-and-clear cycle, i.e. the same cycle count shows 0.
- The level change lands on that same edge. The new step applies from the very next increment.
- Pause at TERMINAL with clear high: clear still wins, so count → 0 and the tick fires.
- Pause elsewhere: count, level and tickcnt all hold.
- Restart and tickcond in the same cycle: restart wins. No tick, and level goes to 0.
- Reset mid-period: all state returns to 0 immediately. No tick pulse is produced.

## Test plan
- Bench configuration: TERMINAL=10, TICKSPERLEVEL=2, MAXLEVEL=3. The bench models the comparator as clear = (data==10) | start.
- Reset then enable=1, start=0 → data goes 0,1,…,10,0.
  - tick is high exactly on the cycle data returns to 0.
  - Period is 11 cycles. level = 0.
- Continue running:
  - After 2 ticks, level = 1, and the period becomes 6 cycles (0,2,4,6,8,10).
  - After 2 more ticks, level = 2, sequence 0,3,6,9,10, saturating at 10.
  - Then level = 3 with sequence 0,4,8,10. level stays 3 after further ticks.
- Hold start=1 for 20 cycles → data stays 0, tick never asserts, tickcnt unchanged.
- enable=0 at data=6 for 5 cycles → data holds 6.
  - Then with data=10 (start=0), enable=0 → data → 0 and the tick fires.
- At level 2, assert restart in the cycle data=10 with clear high → no tick. Next cycle: data=0, level=0, and the next period is 11 cycles.
- Assert asynchronous reset mid-count (data=7, level=1) between edges → outputs become 0 immediately, with no tick pulse.

Source files
------------

// File: rtl/cc_speed_counter_if.sv
// ---------------------------------------------------------------------------
// cc_speed_counter_if
//
// Purpose:
//   Groups the control and result signals of the lane speed counter into one
//   bundle. The counter sits directly upstream of the lane speed comparator.
//   The comparator, or the testbench standing in for it, acts as the master.
//   It drives clear, enable and restart, and it observes the count, the level
//   and the tick pulse. The counter is the slave.
//
// Signals:
//   CC_SPEEDCOUNTER_clear_InHigh    synchronous clear, taken from the comparator
//   CC_SPEEDCOUNTER_enable_InHigh   count enable, 0 pauses and holds
//   CC_SPEEDCOUNTER_restart_InHigh  synchronous game restart
//   CC_SPEEDCOUNTER_data_OutBUS     current count, DATAWIDTH bits
//   CC_SPEEDCOUNTER_level_OutBUS    current game level, LEVELWIDTH bits
//   CC_SPEEDCOUNTER_tick_OutHigh    one-cycle pulse per completed period
// ---------------------------------------------------------------------------
interface cc_speed_counter_if #(
  parameter int unsigned DATAWIDTH  = 24,
  parameter int unsigned LEVELWIDTH = 3
);

  logic                  CC_SPEEDCOUNTER_clear_InHigh;
  logic                  CC_SPEEDCOUNTER_enable_InHigh;
  logic                  CC_SPEEDCOUNTER_restart_InHigh;
  logic [DATAWIDTH-1:0]  CC_SPEEDCOUNTER_data_OutBUS;
  logic [LEVELWIDTH-1:0] CC_SPEEDCOUNTER_level_OutBUS;
  logic                  CC_SPEEDCOUNTER_tick_OutHigh;

  // Comparator / game-control side: drives the controls and watches the count.
  modport master (
    output CC_SPEEDCOUNTER_clear_InHigh,
    output CC_SPEEDCOUNTER_enable_InHigh,
    output CC_SPEEDCOUNTER_restart_InHigh,
    input  CC_SPEEDCOUNTER_data_OutBUS,
    input  CC_SPEEDCOUNTER_level_OutBUS,
    input  CC_SPEEDCOUNTER_tick_OutHigh
  );

  // Counter side: consumes the controls and produces the registered results.
  modport slave (
    input  CC_SPEEDCOUNTER_clear_InHigh,
    input  CC_SPEEDCOUNTER_enable_InHigh,
    input  CC_SPEEDCOUNTER_restart_InHigh,
    output CC_SPEEDCOUNTER_data_OutBUS,
    output CC_SPEEDCOUNTER_level_OutBUS,
    output CC_SPEEDCOUNTER_tick_OutHigh
  );

endinterface

// File: rtl/cc_speed_counter.sv
// ---------------------------------------------------------------------------
// cc_speed_counter
//
// Purpose:
//   Level-aware up-counter for one Frogger lane. The count advances by
//   (level + 1) on every enabled edge. It saturates exactly on the terminal
//   value, so the downstream equality comparator always sees that value. The
//   comparator's clear output comes back to this block as a synchronous clear.
//   Every completed period (terminal value followed by clear) is counted.
//   After TICKSPERLEVEL periods the level rises by one, up to MAXLEVEL, which
//   makes the lane move faster.
//
// Ports:
//   CC_SPEEDCOUNTER_CLOCK_50      in   system clock, rising edge
//   CC_SPEEDCOUNTER_RESET_InHigh  in   asynchronous active-high reset
//   bus (slave modport)                clear/enable/restart in,
//                                      data/level/tick out
//
// Parameters:
//   SPEEDCOUNTER_DATAWIDTH       count bus width
//   SPEEDCOUNTER_TERMINAL        terminal count; must equal the comparator
//                                constant
//   SPEEDCOUNTER_LEVELWIDTH      level register width
//   SPEEDCOUNTER_MAXLEVEL        level saturation value
//   SPEEDCOUNTER_TICKSPERLEVEL   completed periods per level step (1..255)
// ---------------------------------------------------------------------------
module cc_speed_counter #(
  parameter int unsigned                          SPEEDCOUNTER_DATAWIDTH     = 24,
  parameter logic [SPEEDCOUNTER_DATAWIDTH-1:0]    SPEEDCOUNTER_TERMINAL      = 24'd16500000,
  parameter int unsigned                          SPEEDCOUNTER_LEVELWIDTH    = 3,
  parameter int unsigned                          SPEEDCOUNTER_MAXLEVEL      = 7,
  parameter int unsigned                          SPEEDCOUNTER_TICKSPERLEVEL = 8
) (
  input  logic                 CC_SPEEDCOUNTER_CLOCK_50,
  input  logic                 CC_SPEEDCOUNTER_RESET_InHigh,
  cc_speed_counter_if.slave    bus
);

  localparam int unsigned DW = SPEEDCOUNTER_DATAWIDTH;
  localparam int unsigned LW = SPEEDCOUNTER_LEVELWIDTH;
  localparam int unsigned SW = SPEEDCOUNTER_DATAWIDTH + 1;

  localparam logic [SW-1:0] TERMINAL_EXT = {1'b0, SPEEDCOUNTER_TERMINAL};
  localparam logic [LW-1:0] MAX_LEVEL    = LW'(SPEEDCOUNTER_MAXLEVEL);
  localparam logic [7:0]    TICK_LAST    = 8'(SPEEDCOUNTER_TICKSPERLEVEL - 1);

  logic [DW-1:0] count_q,   count_d;
  logic [LW-1:0] level_q,   level_d;
  logic [7:0]    tickCnt_q, tickCnt_d;
  logic          tick_q,    tick_d;

  logic [SW-1:0] step;
  logic [SW-1:0] sum;
  logic          atTerminal;
  logic          tickCond;

  // The step and the sum are one bit wider than the count so that an add
  // near the top of the range cannot wrap. A wrapped sum would slip
  // underneath the saturation test and skip the terminal value.
  assign step       = SW'(level_q) + SW'(1);
  assign sum        = {1'b0, count_q} + step;
  assign atTerminal = (count_q == SPEEDCOUNTER_TERMINAL);

  // A period is complete only when the comparator clears the counter while
  // it sits on the terminal value. A clear at any other count is the
  // comparator's start-hold and does not count as a period. Restart always
  // suppresses the tick. Enable does not gate it, so a paused lane that is
  // already at the terminal value still finishes its period.
  assign tickCond = atTerminal
                  & bus.CC_SPEEDCOUNTER_clear_InHigh
                  & ~bus.CC_SPEEDCOUNTER_restart_InHigh;

  // Next-count selection. Restart comes first, then clear, then pause. When
  // the next step would reach or pass the terminal value, the counter loads
  // the terminal value instead, so the equality comparator never misses it.
  // A count already above the terminal value (possible only if the
  // comparator misbehaved) is also pulled back to the terminal value.
  always_comb begin
    count_d = count_q;
    if (bus.CC_SPEEDCOUNTER_restart_InHigh) begin
      count_d = '0;
    end else if (bus.CC_SPEEDCOUNTER_clear_InHigh) begin
      count_d = '0;
    end else if (!bus.CC_SPEEDCOUNTER_enable_InHigh) begin
      count_d = count_q;
    end else if ((sum >= TERMINAL_EXT) || (count_q > SPEEDCOUNTER_TERMINAL)) begin
      count_d = SPEEDCOUNTER_TERMINAL;
    end else begin
      count_d = sum[DW-1:0];
    end
  end

  // Period bookkeeping. tickCnt counts completed periods within the current
  // level. When it wraps, the level rises by one unless it has reached the
  // maximum. The level change is registered on the same edge as the tick, so
  // the larger step takes effect from the very next increment. Restart
  // returns the game to level 0 with no partial progress kept.
  always_comb begin
    level_d   = level_q;
    tickCnt_d = tickCnt_q;
    tick_d    = tickCond;
    if (bus.CC_SPEEDCOUNTER_restart_InHigh) begin
      level_d   = '0;
      tickCnt_d = '0;
      tick_d    = 1'b0;
    end else if (tickCond) begin
      if (tickCnt_q == TICK_LAST) begin
        tickCnt_d = '0;
        if (level_q < MAX_LEVEL) begin
          level_d = level_q + LW'(1);
        end
      end else begin
        tickCnt_d = tickCnt_q + 8'd1;
      end
    end
  end

  // State registers. Reset clears everything immediately, so a reset in the
  // middle of a period cannot leave a stray tick pulse behind.
  always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or posedge CC_SPEEDCOUNTER_RESET_InHigh) begin
    if (CC_SPEEDCOUNTER_RESET_InHigh) begin
      count_q   <= '0;
      level_q   <= '0;
      tickCnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      level_q   <= level_d;
      tickCnt_q <= tickCnt_d;
      tick_q    <= tick_d;
    end
  end

  // Every output comes straight from a register. This keeps the comparator
  // loop at exactly one register stage.
  assign bus.CC_SPEEDCOUNTER_data_OutBUS  = count_q;
  assign bus.CC_SPEEDCOUNTER_level_OutBUS = level_q;
  assign bus.CC_SPEEDCOUNTER_tick_OutHigh = tick_q;

endmodule
